// File: rtl/filter_pipe_ctrl.sv
// filter_pipe_ctrl: sequences the image filter pipe.
// Owns Enable and Filter_config and only moves them on a frame boundary, so
// no frame is ever split across two filter modes. Mode changes arrive on a
// single-cycle req/ack handshake; optional auto-cycling steps the mode every
// FRAMES_PER_MODE frames while the pipe is running.
module filter_pipe_ctrl #(
   parameter int unsigned FRAMES_PER_MODE = 60,
   parameter int unsigned MODE_MAX        = 5
) (
   input  logic        Clock,
   input  logic        Resetn,
   input  logic        Clock_en,
   input  logic [10:0] H_Count,
   input  logic [9:0]  V_Count,
   input  logic        Run_req,
   input  logic        Auto_cycle,
   input  logic        Cfg_req,
   input  logic [2:0]  Cfg_mode,
   output logic        Cfg_ack,
   output logic        Cfg_err,
   output logic        Enable,
   output logic [31:0] Filter_config,
   output logic        Busy
);

   typedef enum logic [1:0] {
      S_OFF,
      S_ARM,
      S_ON,
      S_DRAIN
   } state_t;

   state_t     state, state_nxt;
   logic       enable_nxt;
   logic       fs;
   logic       cfg_legal;
   logic       cfg_ok;
   logic       apply_old;
   logic       auto_act;
   logic [2:0] mode_q, mode_nxt;
   logic [2:0] pend_q, pend_nxt;
   logic       busy_nxt;
   logic [7:0] cnt_q, cnt_nxt;

   // Frame start strobe and request classification
   always_comb begin
      fs        = Clock_en && (H_Count == 11'd0) && (V_Count == 10'd0);
      cfg_legal = ({29'd0, Cfg_mode} <= MODE_MAX);
      cfg_ok    = Cfg_req && cfg_legal;
   end

   // Run FSM next-state; Enable follows the state being entered
   always_comb begin
      state_nxt = state;
      case (state)
         S_OFF:   if (Run_req) state_nxt = S_ARM;
         S_ARM:   if (!Run_req) state_nxt = S_OFF;
                  else if (fs) state_nxt = S_ON;
         S_ON:    if (!Run_req) state_nxt = S_DRAIN;
         S_DRAIN: if (Run_req) state_nxt = S_ON;
                  else if (fs) state_nxt = S_OFF;
         default: state_nxt = S_OFF;
      endcase
      enable_nxt = (state_nxt == S_ON) || (state_nxt == S_DRAIN);
   end

   // Mode/pending/counter next values. In OFF a legal request is applied
   // directly so the config moves on the ack edge; otherwise an older pending
   // mode is applied at fs while a same-cycle request becomes the new pending.
   always_comb begin
      mode_nxt  = mode_q;
      pend_nxt  = pend_q;
      busy_nxt  = Busy;
      cnt_nxt   = cnt_q;
      apply_old = Busy && ((state == S_OFF) || fs);
      auto_act  = (state == S_ON) && Auto_cycle && !Busy;
      if (cfg_ok && (state == S_OFF)) begin
         mode_nxt = Cfg_mode;
         pend_nxt = Cfg_mode;
         busy_nxt = 1'b0;
         cnt_nxt  = '0;
      end else begin
         if (cfg_ok) begin
            pend_nxt = Cfg_mode;
            busy_nxt = 1'b1;
         end else if (apply_old) begin
            busy_nxt = 1'b0;
         end
         if (apply_old) begin
            mode_nxt = pend_q;
            cnt_nxt  = '0;
         end else if (auto_act && fs) begin
            if (cnt_q == 8'(FRAMES_PER_MODE - 1)) begin
               mode_nxt = (mode_q == 3'(MODE_MAX)) ? 3'd0 : mode_q + 3'd1;
               cnt_nxt  = '0;
            end else begin
               cnt_nxt = cnt_q + 8'd1;
            end
         end
      end
   end

   // State and output registers
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state   <= S_OFF;
         Enable  <= 1'b0;
         mode_q  <= '0;
         pend_q  <= '0;
         Busy    <= 1'b0;
         cnt_q   <= '0;
         Cfg_ack <= 1'b0;
         Cfg_err <= 1'b0;
      end else begin
         state   <= state_nxt;
         Enable  <= enable_nxt;
         mode_q  <= mode_nxt;
         pend_q  <= pend_nxt;
         Busy    <= busy_nxt;
         cnt_q   <= cnt_nxt;
         Cfg_ack <= cfg_ok;
         Cfg_err <= Cfg_req && !cfg_legal;
      end
   end

   // Upper config bits are reserved and held at zero
   always_comb begin
      Filter_config = {29'd0, mode_q};
   end

endmodule

// File: tb/tb_filter_pipe_ctrl.sv
// tb_filter_pipe_ctrl: scenario bench for filter_pipe_ctrl with a small
// VGA-style timing generator (4 pixels x 320 lines) and FRAMES_PER_MODE=2.
// Expected output vectors are queued as stimulus is applied and popped when
// the DUT's response is sampled.
module tb_filter_pipe_ctrl;

   localparam int unsigned H_LAST = 3;
   localparam int unsigned V_LAST = 319;
   localparam int unsigned BUDGET = 6000;

   logic        Clock;
   logic        Resetn;
   logic        Clock_en;
   logic [10:0] H_Count;
   logic [9:0]  V_Count;
   logic        Run_req;
   logic        Auto_cycle;
   logic        Cfg_req;
   logic [2:0]  Cfg_mode;
   logic        Cfg_ack;
   logic        Cfg_err;
   logic        Enable;
   logic [31:0] Filter_config;
   logic        Busy;

   typedef struct {
      string       tag;
      logic [35:0] val;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   filter_pipe_ctrl #(
      .FRAMES_PER_MODE(2),
      .MODE_MAX(5)
   ) dut (
      .Clock(Clock),
      .Resetn(Resetn),
      .Clock_en(Clock_en),
      .H_Count(H_Count),
      .V_Count(V_Count),
      .Run_req(Run_req),
      .Auto_cycle(Auto_cycle),
      .Cfg_req(Cfg_req),
      .Cfg_mode(Cfg_mode),
      .Cfg_ack(Cfg_ack),
      .Cfg_err(Cfg_err),
      .Enable(Enable),
      .Filter_config(Filter_config),
      .Busy(Busy)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   // Pixel timing source: changes on the falling edge, away from DUT sampling
   initial begin
      Clock_en = 1'b0;
      H_Count  = '0;
      V_Count  = '0;
   end
   always @(negedge Clock) begin
      if (Clock_en) begin
         if (H_Count == 11'(H_LAST)) begin
            H_Count = '0;
            V_Count = (V_Count == 10'(V_LAST)) ? 10'd0 : V_Count + 10'd1;
         end else begin
            H_Count = H_Count + 11'd1;
         end
      end
      Clock_en = ~Clock_en;
   end

   function automatic logic [35:0] st(input logic en, input logic bsy,
                                      input logic ack, input logic err,
                                      input logic [2:0] m);
      return {en, bsy, ack, err, 29'd0, m};
   endfunction

   task automatic check(input string tag, input logic [35:0] obs,
                        input logic [35:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got en/busy/ack/err=%b cfg=%h, want en/busy/ack/err=%b cfg=%h",
                  tag, obs[35:32], obs[31:0], exp[35:32], exp[31:0]);
      end
   endtask

   task automatic push(input string tag, input logic [35:0] val);
      exp_t e;
      e.tag = tag;
      e.val = val;
      sb.push_back(e);
   endtask

   // Pop the oldest expectation and compare it against the outputs right now
   task automatic pop_cmp();
      exp_t e;
      if (sb.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL scoreboard_empty: got output with no expectation queued");
      end else begin
         e = sb.pop_front();
         check(e.tag, {Enable, Busy, Cfg_ack, Cfg_err, Filter_config}, e.val);
      end
   endtask

   task automatic timeout(input string tag);
      n_checks++;
      n_fail++;
      $display("FAIL %s: wait expired after %0d cycles, want event", tag, BUDGET);
   endtask

   // Return 1 time unit after the edge that ends the next fs cycle
   task automatic wait_fs();
      bit hit;
      hit = 1'b0;
      for (int unsigned i = 0; i < BUDGET && !hit; i++) begin
         @(posedge Clock);
         if (Clock_en && H_Count == 11'd0 && V_Count == 10'd0) hit = 1'b1;
         #1;
      end
      if (!hit) timeout("wait_fs");
   endtask

   task automatic wait_line(input int unsigned v);
      bit hit;
      hit = 1'b0;
      for (int unsigned i = 0; i < BUDGET && !hit; i++) begin
         @(posedge Clock);
         #1;
         if (V_Count == 10'(v)) hit = 1'b1;
      end
      if (!hit) timeout("wait_line");
   endtask

   task automatic step(input int unsigned n);
      repeat (n) begin
         @(posedge Clock);
         #1;
      end
   endtask

   // One-cycle request; returns just after the edge that answers it
   task automatic cfg_pulse(input logic [2:0] m);
      Cfg_req  = 1'b1;
      Cfg_mode = m;
      @(posedge Clock);
      #1;
      Cfg_req  = 1'b0;
   endtask

   initial begin
      Resetn     = 1'b0;
      Run_req    = 1'b0;
      Auto_cycle = 1'b0;
      Cfg_req    = 1'b0;
      Cfg_mode   = '0;

      // Reset state
      step(3);
      push("reset", st(0, 0, 0, 0, 0));
      pop_cmp();
      Resetn = 1'b1;

      // Idle for two frames, then arm mid-frame
      for (int f = 0; f < 2; f++) begin
         wait_fs();
         push("idle_off", st(0, 0, 0, 0, 0));
         pop_cmp();
      end
      wait_line(100);
      Run_req = 1'b1;
      step(4);
      push("armed_wait", st(0, 0, 0, 0, 0));
      pop_cmp();
      wait_fs();
      push("enable_at_fs", st(1, 0, 0, 0, 0));
      pop_cmp();

      // Mode change while running
      wait_line(100);
      cfg_pulse(3'd2);
      push("m2_ack", st(1, 1, 1, 0, 0));
      pop_cmp();
      step(1);
      push("m2_ack_drop", st(1, 1, 0, 0, 0));
      pop_cmp();
      wait_fs();
      push("m2_applied", st(1, 0, 0, 0, 2));
      pop_cmp();

      // Illegal mode, then overwrite within one frame
      wait_line(50);
      cfg_pulse(3'd6);
      push("m6_err", st(1, 0, 0, 1, 2));
      pop_cmp();
      step(1);
      push("m6_err_drop", st(1, 0, 0, 0, 2));
      pop_cmp();
      cfg_pulse(3'd3);
      push("m3_ack", st(1, 1, 1, 0, 2));
      pop_cmp();
      step(2);
      cfg_pulse(3'd5);
      push("m5_ack", st(1, 1, 1, 0, 2));
      pop_cmp();
      wait_fs();
      push("m5_applied", st(1, 0, 0, 0, 5));
      pop_cmp();

      // Auto-cycle from mode 4 with two frames per mode
      wait_line(10);
      cfg_pulse(3'd4);
      wait_fs();
      push("auto_start4", st(1, 0, 0, 0, 4));
      pop_cmp();
      Auto_cycle = 1'b1;
      push("auto_fs1", st(1, 0, 0, 0, 4));
      push("auto_fs2", st(1, 0, 0, 0, 5));
      push("auto_fs3", st(1, 0, 0, 0, 5));
      push("auto_fs4", st(1, 0, 0, 0, 0));
      push("auto_fs5", st(1, 0, 0, 0, 0));
      push("auto_fs6", st(1, 0, 0, 0, 1));
      for (int f = 0; f < 6; f++) begin
         wait_fs();
         pop_cmp();
      end
      // Manual request mid-period restarts the count
      wait_line(20);
      cfg_pulse(3'd2);
      wait_fs();
      push("man2_fs7", st(1, 0, 0, 0, 2));
      pop_cmp();
      wait_fs();
      push("man2_fs8", st(1, 0, 0, 0, 2));
      pop_cmp();
      wait_fs();
      push("man2_fs9", st(1, 0, 0, 0, 3));
      pop_cmp();
      wait_fs();
      push("hold_fs10", st(1, 0, 0, 0, 3));
      pop_cmp();
      // Manual request in the frame that would auto-step: manual wins
      wait_line(20);
      cfg_pulse(3'd0);
      wait_fs();
      push("man0_fs11", st(1, 0, 0, 0, 0));
      pop_cmp();
      wait_fs();
      push("man0_fs12", st(1, 0, 0, 0, 0));
      pop_cmp();
      wait_fs();
      push("man0_fs13", st(1, 0, 0, 0, 1));
      pop_cmp();
      Auto_cycle = 1'b0;

      // Drain to OFF
      wait_line(200);
      Run_req = 1'b0;
      step(4);
      push("drain_hold", st(1, 0, 0, 0, 1));
      pop_cmp();
      wait_fs();
      push("drain_off", st(0, 0, 0, 0, 1));
      pop_cmp();
      // Request in OFF updates the config on the ack edge
      wait_line(40);
      cfg_pulse(3'd3);
      push("off_apply", st(0, 0, 1, 0, 3));
      pop_cmp();
      Run_req = 1'b1;
      wait_fs();
      push("rearm_on", st(1, 0, 0, 0, 3));
      pop_cmp();
      // Drain aborted before fs
      wait_line(200);
      Run_req = 1'b0;
      wait_line(250);
      Run_req = 1'b1;
      wait_fs();
      push("drain_abort", st(1, 0, 0, 0, 3));
      pop_cmp();

      // Asynchronous reset with a change pending
      wait_line(290);
      cfg_pulse(3'd4);
      push("pend4_ack", st(1, 1, 1, 0, 3));
      pop_cmp();
      wait_line(300);
      Resetn = 1'b0;
      #1;
      push("async_reset", st(0, 0, 0, 0, 0));
      pop_cmp();
      step(3);
      Resetn = 1'b1;
      step(3);
      push("post_reset_arm", st(0, 0, 0, 0, 0));
      pop_cmp();
      wait_fs();
      push("post_reset_on", st(1, 0, 0, 0, 0));
      pop_cmp();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
